// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared core widths and write-back request type
// Purpose: common register-file widths and the {rd, data} write-back request.
// Contents: XLEN, REG_ADDR_W, wb_req_t.
package riscv_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - long-latency write-back result queue
// Purpose: FIFO of wb_req_t entries with full/empty flags.
// Ports:
//   clk, reset_n       : clock, asynchronous active-low reset
//   push, push_req     : enqueue strobe and entry (ignored when full)
//   pop                : dequeue strobe (ignored when empty)
//   head               : oldest entry, valid while !empty
//   full, empty        : occupancy flags, from registered pointers only
module wb_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic    clk,
  input  logic    reset_n,
  input  logic    push,
  input  wb_req_t push_req,
  input  logic    pop,
  output wb_req_t head,
  output logic    full,
  output logic    empty
);

  localparam int AW = $clog2(DEPTH);

  // One extra pointer bit distinguishes full from empty when indices match.
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  wb_req_t     mem [DEPTH];

  logic do_push;
  logic do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage needs no reset: entries are only read while the queue is non-empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_req;
  end

endmodule

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - register-file write-back arbiter and scoreboard
// Purpose: merges single-cycle ALU results and queued long-latency results onto
// the single register-file write port, tracks outstanding long-latency writes,
// and raises a decode stall on hazards against them.
// Ports:
//   clk, reset_n                      : clock, asynchronous active-low reset
//   alu_valid, alu_rd, alu_data       : ALU result (no backpressure but alu_hold)
//   lsu_valid, lsu_ready, lsu_rd/data : long-latency result handshake
//   issue_valid, issue_rd             : long-latency op issue, marks rd busy
//   dec_rs1, dec_rs2, dec_rd          : decode-stage register indices
//   hazard_stall                      : combinational decode stall
//   alu_hold                          : registered, one-cycle ALU freeze to drain queue
//   busy                              : scoreboard, bit 0 always 0
//   reg_write, rd_sel, wb_data        : registered register-file write port
module wb_arbiter
  import riscv_pkg::*;
#(
  parameter int LQ_DEPTH   = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  alu_valid,
  input  logic [REG_ADDR_W-1:0] alu_rd,
  input  logic [XLEN-1:0]       alu_data,
  input  logic                  lsu_valid,
  output logic                  lsu_ready,
  input  logic [REG_ADDR_W-1:0] lsu_rd,
  input  logic [XLEN-1:0]       lsu_data,
  input  logic                  issue_valid,
  input  logic [REG_ADDR_W-1:0] issue_rd,
  input  logic [REG_ADDR_W-1:0] dec_rs1,
  input  logic [REG_ADDR_W-1:0] dec_rs2,
  input  logic [REG_ADDR_W-1:0] dec_rd,
  output logic                  hazard_stall,
  output logic                  alu_hold,
  output logic [31:0]           busy,
  output logic                  reg_write,
  output logic [REG_ADDR_W-1:0] rd_sel,
  output logic [XLEN-1:0]       wb_data
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_TRIP = CNT_W'(STARVE_MAX - 1);

  logic            q_full;
  logic            q_empty;
  logic            q_push;
  logic            q_pop;
  wb_req_t         q_head;
  wb_req_t         push_req;
  logic            alu_win;
  logic            wb_from_q;
  logic [CNT_W-1:0] starve_cnt;
  logic [31:0]     busy_next;

  assign push_req.rd   = lsu_rd;
  assign push_req.data = lsu_data;

  // x0 results are accepted by the handshake but never reach the queue.
  assign lsu_ready = !q_full;
  assign q_push    = lsu_valid && !q_full && (lsu_rd != '0);

  // An ALU write offered during alu_hold is dropped so the queue head wins.
  assign alu_win = alu_valid && (alu_rd != '0) && !alu_hold;
  assign q_pop   = !q_empty && !alu_win;

  wb_fifo #(
    .DEPTH (LQ_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (q_push),
    .push_req (push_req),
    .pop      (q_pop),
    .head     (q_head),
    .full     (q_full),
    .empty    (q_empty)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      reg_write <= 1'b0;
      wb_from_q <= 1'b0;
      rd_sel    <= '0;
      wb_data   <= '0;
    end else begin
      reg_write <= alu_win || q_pop;
      wb_from_q <= q_pop;
      if (alu_win) begin
        rd_sel  <= alu_rd;
        wb_data <= alu_data;
      end else if (q_pop) begin
        rd_sel  <= q_head.rd;
        wb_data <= q_head.data;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      starve_cnt <= '0;
      alu_hold   <= 1'b0;
    end else begin
      alu_hold <= 1'b0;
      if (q_pop) begin
        starve_cnt <= '0;
      end else if (!q_empty && alu_win) begin
        if (starve_cnt == STARVE_TRIP) begin
          starve_cnt <= '0;
          alu_hold   <= 1'b1;
        end else begin
          starve_cnt <= starve_cnt + CNT_W'(1);
        end
      end
    end
  end

  // Clear follows the queued write's actual commit cycle; a same-edge issue
  // to the same register re-marks it, so set is applied last.
  always_comb begin
    busy_next = busy;
    if (wb_from_q) busy_next[rd_sel] = 1'b0;
    if (issue_valid) busy_next[issue_rd] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) busy <= '0;
    else          busy <= busy_next;
  end

  assign hazard_stall = busy[dec_rs1] | busy[dec_rs2] | busy[dec_rd];

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - directed self-checking bench for wb_arbiter
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        lsu_valid;
  logic        lsu_ready;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_data;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic [4:0]  dec_rs1;
  logic [4:0]  dec_rs2;
  logic [4:0]  dec_rd;
  logic        hazard_stall;
  logic        alu_hold;
  logic [31:0] busy;
  logic        reg_write;
  logic [4:0]  rd_sel;
  logic [31:0] wb_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_arbiter #(.LQ_DEPTH(2), .STARVE_MAX(4)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .alu_valid    (alu_valid),
    .alu_rd       (alu_rd),
    .alu_data     (alu_data),
    .lsu_valid    (lsu_valid),
    .lsu_ready    (lsu_ready),
    .lsu_rd       (lsu_rd),
    .lsu_data     (lsu_data),
    .issue_valid  (issue_valid),
    .issue_rd     (issue_rd),
    .dec_rs1      (dec_rs1),
    .dec_rs2      (dec_rs2),
    .dec_rd       (dec_rd),
    .hazard_stall (hazard_stall),
    .alu_hold     (alu_hold),
    .busy         (busy),
    .reg_write    (reg_write),
    .rd_sel       (rd_sel),
    .wb_data      (wb_data)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic alu(input logic v, input logic [4:0] rd, input logic [31:0] d);
    alu_valid = v; alu_rd = rd; alu_data = d;
  endtask

  task automatic lsu(input logic v, input logic [4:0] rd, input logic [31:0] d);
    lsu_valid = v; lsu_rd = rd; lsu_data = d;
  endtask

  task automatic iss(input logic v, input logic [4:0] rd);
    issue_valid = v; issue_rd = rd;
  endtask

  // Protocol monitor: no ALU write during alu_hold, no ALU write to a busy rd.
  always @(negedge clk) begin
    if (reset_n === 1'b1 && alu_valid === 1'b1) begin
      checks++;
      assert (alu_hold === 1'b0) else begin
        errors++;
        $error("FAIL alu_during_hold observed=%b expected=0", alu_hold);
      end
      if (alu_rd != 5'd0) begin
        checks++;
        assert (busy[alu_rd] === 1'b0) else begin
          errors++;
          $error("FAIL waw_alu_to_busy rd=%0d busy=%h expected bit clear", alu_rd, busy);
        end
      end
    end
  end

  initial begin
    reset_n = 1'b0;
    alu(0, 0, 0); lsu(0, 0, 0); iss(0, 0);
    dec_rs1 = 0; dec_rs2 = 0; dec_rd = 0;

    // Reset state
    tick(); tick();
    chk("rst_reg_write", 32'(reg_write), 0);
    chk("rst_rd_sel", 32'(rd_sel), 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_alu_hold", 32'(alu_hold), 0);
    chk("rst_lsu_ready", 32'(lsu_ready), 1);
    reset_n = 1'b1;
    tick();
    chk("post_rst_lsu_ready", 32'(lsu_ready), 1);

    // ALU priority over LSU in the same cycle
    alu(1, 5, 32'hDEAD_BEEF); lsu(1, 6, 32'h0000_1234);
    tick();
    alu(0, 0, 0); lsu(0, 0, 0);
    chk("prio_n1_we", 32'(reg_write), 1);
    chk("prio_n1_rd", 32'(rd_sel), 5);
    chk("prio_n1_data", wb_data, 32'hDEAD_BEEF);
    tick();
    chk("prio_n2_we", 32'(reg_write), 1);
    chk("prio_n2_rd", 32'(rd_sel), 6);
    chk("prio_n2_data", wb_data, 32'h0000_1234);
    tick();
    chk("prio_n3_we", 32'(reg_write), 0);
    chk("prio_n3_rd_hold", 32'(rd_sel), 6);
    chk("prio_n3_data_hold", wb_data, 32'h0000_1234);

    // Scoreboard: issue x7, stall through the LSU commit
    iss(1, 7);
    #1 chk("sb_n0_stall", 32'(hazard_stall), 0);
    tick();
    iss(0, 0); dec_rs1 = 7;
    #1 chk("sb_n1_busy", busy, 32'h0000_0080);
    chk("sb_n1_stall", 32'(hazard_stall), 1);
    tick();
    chk("sb_n2_stall", 32'(hazard_stall), 1);
    tick();
    lsu(1, 7, 32'h0000_0077);
    #1 chk("sb_n3_stall", 32'(hazard_stall), 1);
    chk("sb_n3_ready", 32'(lsu_ready), 1);
    tick();
    lsu(0, 0, 0);
    chk("sb_n4_stall", 32'(hazard_stall), 1);
    tick();
    chk("sb_n5_stall", 32'(hazard_stall), 1);
    chk("sb_n5_rd", 32'(rd_sel), 7);
    chk("sb_n5_data", wb_data, 32'h0000_0077);
    tick();
    chk("sb_n6_stall", 32'(hazard_stall), 0);
    chk("sb_n6_busy", busy, 0);
    dec_rs1 = 0;

    // Starvation: x9 queued, ALU writes x1..x4
    lsu(1, 9, 32'h0000_0099);
    tick();
    lsu(0, 0, 0);
    for (int i = 1; i <= 4; i++) begin
      alu(1, 5'(i), 32'h100 + 32'(i));
      #1 chk("starve_hold_low", 32'(alu_hold), 0);
      tick();
    end
    alu(0, 0, 0);
    chk("starve_hold_high", 32'(alu_hold), 1);
    chk("starve_last_alu_rd", 32'(rd_sel), 4);
    tick();
    chk("starve_hold_clear", 32'(alu_hold), 0);
    chk("starve_q_we", 32'(reg_write), 1);
    chk("starve_q_rd", 32'(rd_sel), 9);
    chk("starve_q_data", wb_data, 32'h0000_0099);

    // Full queue: three LSU offers while the ALU writes every cycle
    alu(1, 11, 32'h11); lsu(1, 10, 32'hA0);
    #1 chk("full_b0_ready", 32'(lsu_ready), 1);
    tick();
    alu(1, 13, 32'h13); lsu(1, 12, 32'hA1);
    #1 chk("full_b1_ready", 32'(lsu_ready), 1);
    tick();
    alu(1, 11, 32'h11); lsu(1, 14, 32'hA2);
    #1 chk("full_b2_ready", 32'(lsu_ready), 0);
    tick();
    alu(1, 13, 32'h13);
    #1 chk("full_b3_ready", 32'(lsu_ready), 0);
    tick();
    alu(1, 11, 32'h11);
    #1 chk("full_b4_ready", 32'(lsu_ready), 0);
    chk("full_b4_hold", 32'(alu_hold), 0);
    tick();
    alu(0, 0, 0);
    chk("full_b5_hold", 32'(alu_hold), 1);
    chk("full_b5_ready_while_pop", 32'(lsu_ready), 0);
    tick();
    chk("full_b6_ready", 32'(lsu_ready), 1);
    chk("full_b6_rd", 32'(rd_sel), 10);
    chk("full_b6_data", wb_data, 32'hA0);
    tick();
    lsu(0, 0, 0);
    chk("full_b7_rd", 32'(rd_sel), 12);
    chk("full_b7_data", wb_data, 32'hA1);
    tick();
    chk("full_b8_rd", 32'(rd_sel), 14);
    chk("full_b8_data", wb_data, 32'hA2);
    tick();
    chk("full_b9_we", 32'(reg_write), 0);

    // x0 filtering
    alu(1, 0, 32'h55); lsu(1, 0, 32'h66); iss(1, 0);
    #1 chk("x0_ready", 32'(lsu_ready), 1);
    tick();
    alu(0, 0, 0); lsu(0, 0, 0); iss(0, 0);
    chk("x0_c1_we", 32'(reg_write), 0);
    chk("x0_c1_busy", busy, 0);
    tick();
    chk("x0_c2_we", 32'(reg_write), 0);

    // Set/clear collision on x3
    iss(1, 3);
    tick();
    iss(0, 0); lsu(1, 3, 32'h33);
    tick();
    lsu(0, 0, 0);
    tick();
    chk("coll_d3_rd", 32'(rd_sel), 3);
    chk("coll_d3_busy", busy, 32'h0000_0008);
    iss(1, 3);
    tick();
    iss(0, 0);
    chk("coll_d4_busy_set_wins", busy, 32'h0000_0008);
    chk("coll_d4_we", 32'(reg_write), 0);
    lsu(1, 3, 32'h34);
    tick();
    lsu(0, 0, 0);
    tick();
    chk("coll_d6_data", wb_data, 32'h34);
    tick();
    chk("coll_d7_busy", busy, 0);

    // Asynchronous reset mid-traffic
    iss(1, 2);
    tick();
    iss(1, 5); lsu(1, 20, 32'h2020);
    tick();
    iss(0, 0); lsu(0, 0, 0); alu(1, 1, 32'h11);
    chk("mid_busy", busy, 32'h0000_0024);
    tick();
    alu(0, 0, 0);
    chk("mid_we", 32'(reg_write), 1);
    chk("mid_rd", 32'(rd_sel), 1);
    reset_n = 1'b0;
    #1;
    chk("arst_we", 32'(reg_write), 0);
    chk("arst_rd", 32'(rd_sel), 0);
    chk("arst_data", wb_data, 0);
    chk("arst_busy", busy, 0);
    chk("arst_hold", 32'(alu_hold), 0);
    chk("arst_ready", 32'(lsu_ready), 1);
    #2 reset_n = 1'b1;
    tick();
    tick();
    chk("arst_queue_flushed_we", 32'(reg_write), 0);
    chk("arst_busy_after", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Write-back arbiter and scoreboard in front of the core's register file write port. It merges single-cycle ALU results and long-latency LSU/MUL-DIV results onto the file's single write port (`reg_write`, `rd_sel`, `wb_data`). It tracks registers with an outstanding long-latency write and raises a decode stall on RAW/WAW hazards against them. Sits between the execute/memory stages and the register file.

## Interface

Parameters:
- `LQ_DEPTH`, default 2: entries in the long-latency result queue. Must be a power of two, at least 2.
- `STARVE_MAX`, default 4: cycles a non-empty queue may be bypassed by ALU writes before `alu_hold` fires.

Ports:
- `clk` in 1: core clock; all state on rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `alu_valid` in 1: ALU result present this cycle. No backpressure except `alu_hold`.
- `alu_rd` in 5: ALU destination.
- `alu_data` in 32: ALU result.
- `lsu_valid` in 1: long-latency result offered.
- `lsu_ready` out 1: queue can accept. Transfer happens when `lsu_valid & lsu_ready`.
- `lsu_rd` in 5: long-latency destination.
- `lsu_data` in 32: long-latency result.
- `issue_valid` in 1: a long-latency op issues this cycle.
- `issue_rd` in 5: destination of the issuing op.
- `dec_rs1` in 5: decode-stage source 1.
- `dec_rs2` in 5: decode-stage source 2.
- `dec_rd` in 5: decode-stage destination.
- `hazard_stall` out 1: combinational decode stall.
- `alu_hold` out 1: registered; freezes EX/WB for one cycle so the queue drains.
- `busy` out 32: scoreboard bits; bit 0 is always 0.
- `reg_write` out 1: register file write enable, registered.
- `rd_sel` out 5: register file write address, registered.
- `wb_data` out 32: register file write data, registered.

## Operation

- **Reset.** While `reset_n` is low: `reg_write`=0, `rd_sel`=0, `wb_data`=0, `busy`=0, `alu_hold`=0, queue empty, starve counter 0. After release, `lsu_ready`=1.
- **x0 filtering.**
  - `alu_valid` with `alu_rd`=0 produces no write.
  - An LSU transfer with `lsu_rd`=0 is accepted but not enqueued.
  - `issue_rd`=0 never sets busy.
- **Queue.** FIFO of {rd, data}, depth `LQ_DEPTH`. `lsu_ready` = !full; it is combinational from registered state, not from `lsu_valid`. A full queue that dequeues this cycle still deasserts `lsu_ready`; there is no same-cycle pass-through.
- **Arbitration per cycle.**
  - Outside `alu_hold`: a qualifying ALU write wins. Otherwise the queue head is dequeued.
  - During `alu_hold`: the queue head wins.
  - The winner is registered onto `reg_write`/`rd_sel`/`wb_data`. With no winner, `reg_write`=0 and `rd_sel`/`wb_data` hold their values.
- **Starvation.**
  - The counter increments each cycle the queue is non-empty and the ALU wins.
  - It clears on any dequeue.
  - When the counter reaches `STARVE_MAX`, `alu_hold` is 1 for exactly the next cycle and the counter clears.
  - `alu_valid` high during `alu_hold` is a protocol violation: the ALU write is dropped and the bench flags it.
- **Scoreboard.**
  - `issue_valid` sets `busy[issue_rd]` at the clock edge.
  - `busy[rd_sel]` clears at the edge ending any cycle in which `reg_write`=1 came from the queue, i.e. when the register file actually commits.
  - If a set and a clear hit the same index on the same edge, set wins.
- **Hazard.** `hazard_stall` = `busy[dec_rs1]` | `busy[dec_rs2]` | `busy[dec_rd]`. x0 is never busy.
- **WAW.** An ALU write to a busy rd is illegal; decode stalling prevents it. The bench asserts it never occurs.

## Timing

- **ALU path:** `alu_valid` in cycle N gives `reg_write`=1 in N+1, and the register file commits at the end of N+1.
- **LSU path:** accepted in cycle N; earliest dequeue is N+1, so earliest `reg_write` is N+2. `busy` clears at the end of N+2 and is visible low in N+3.
- **Issue:** `issue_valid` in cycle N gives `busy` high and `hazard_stall` possible from N+1.
- **Throughput:** one register file write per cycle. The queue sustains one accept per cycle only while it is draining.
- **Reset mid-operation:** the queue contents and all busy bits are discarded. Pipeline flush is the upstream's responsibility.

## Structure

- Shared `riscv_pkg` holds `XLEN`=32, `REG_ADDR_W`=5, and `wb_req_t` (`rd`, `data`).
- One sub-module, `wb_fifo`, implements the parameterized queue with full/empty flags and pointer wrap.
- Arbitration, the starve counter and the scoreboard live in `wb_arbiter`.

## Test plan

- **Reset:** assert `reset_n`=0 mid-traffic with busy=0x0000_0024 → all outputs 0, `busy`=0, `lsu_ready`=1 immediately (asynchronous).
- **ALU priority:**
  - Stimulus: ALU x5=0xDEAD_BEEF and LSU x6=0x1234 in the same cycle N.
  - Response: N+1 shows `rd_sel`=5; N+2 shows `rd_sel`=6 with data 0x1234.
- **Scoreboard:**
  - Stimulus: issue x7 in N; decode rs1=7 in N+1; LSU x7 accepted in N+3.
  - Response: `hazard_stall`=1 from N+1 through N+5; 0 in N+6.
- **Starvation:**
  - Stimulus: queue holds x9; ALU writes x1..x4 continuously.
  - Response: `alu_hold`=1 in the cycle after the 4th bypass; x9 written next.
- **Full queue:**
  - Stimulus: 3 back-to-back LSU offers with `LQ_DEPTH`=2 and ALU busy every cycle.
  - Response: `lsu_ready`=0 after 2 accepts; the third is held until a dequeue.
- **x0 and set/clear collision:**
  - LSU write to x0 → no `reg_write`, no enqueue.
  - Issue x3 on the same edge as the queue commit of x3 → `busy[3]` stays 1.
